// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding RV32I load/store engine in front of a word-wide memory
//   with a combinational read port. Sub-word stores are read-modify-write.
//
//   Ports
//     clk, rst              clock, synchronous active-high reset
//     req_valid/req_ready   request handshake; req_write, req_funct3,
//                           req_addr (byte address), req_wdata (right-aligned)
//     resp_valid            one-cycle completion pulse
//     resp_rdata            extended load result (0 for stores and errors)
//     resp_error            error flag, meaningful only with resp_valid
//     mem_write             one-cycle write strobe
//     mem_address           word index into memory
//     mem_wdata             full write word
//     mem_rdata             combinational read word for mem_address
//     state_dbg             current FSM state, for observation only
//
//   Handshake: a request transfers on a rising edge where req_valid and
//   req_ready are both 1. req_ready is 1 only while idle; the requester holds
//   its request stable until that edge, and req_valid is ignored otherwise.
//
//   Build option: define LSU_MISALIGN_TRAP_EN to report misaligned halfword
//   and word accesses as errors; otherwise they are aligned down silently.

module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    // One extra bit so the comparison is safe for any MEM_WORDS up to 2^30.
    localparam logic [30:0] MEM_LIMIT = 31'(MEM_WORDS);

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] word_q;
    logic [31:0] mem_addr_q;
    logic        accept;
    logic        req_err;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic [31:0] store_word;

    assign accept = req_valid && req_ready;

    // Error classification of the request on the input bus.
    always_comb begin
        req_err = 1'b0;
        if (req_write) begin
            if (!(req_funct3 == F_B || req_funct3 == F_H || req_funct3 == F_W))
                req_err = 1'b1;
        end else begin
            if (!(req_funct3 == F_B || req_funct3 == F_H || req_funct3 == F_W ||
                  req_funct3 == F_BU || req_funct3 == F_HU))
                req_err = 1'b1;
        end
        if ({1'b0, req_addr[31:2]} >= MEM_LIMIT)
            req_err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_funct3 == F_H || req_funct3 == F_HU) && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == F_W && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (req_err)                 state_nxt = S_RESP;
                    else if (!req_write)         state_nxt = S_READ;
                    else if (req_funct3 == F_W)  state_nxt = S_WRITE;
                    else                         state_nxt = S_READ;  // SB/SH merge
                end
            end
            S_READ:  state_nxt = write_q ? S_WRITE : S_RESP;
            S_WRITE: state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture and read-word register. mem_addr_q only moves for
    // requests that will touch memory, so errors leave the bus untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q     <= 32'h0;
            funct3_q   <= 3'b000;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
            err_q      <= 1'b0;
            word_q     <= 32'h0;
            mem_addr_q <= 32'h0;
        end else begin
            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                write_q  <= req_write;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
                if (!req_err)
                    mem_addr_q <= {2'b00, req_addr[31:2]};
            end
            if (state == S_READ)
                word_q <= mem_rdata;
        end
    end

    // Load lane selection from the registered read word.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_byte = word_q[7:0];
            2'd1:    load_byte = word_q[15:8];
            2'd2:    load_byte = word_q[23:16];
            default: load_byte = word_q[31:24];
        endcase
        load_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
        case (funct3_q)
            F_B:     load_val = {{24{load_byte[7]}}, load_byte};
            F_BU:    load_val = {24'h0, load_byte};
            F_H:     load_val = {{16{load_half[15]}}, load_half};
            F_HU:    load_val = {16'h0, load_half};
            default: load_val = word_q;
        endcase
    end

    // Store word: sub-word stores splice into the word read in READ.
    always_comb begin
        store_word = word_q;
        case (funct3_q)
            F_B: begin
                case (addr_q[1:0])
                    2'd0:    store_word[7:0]   = wdata_q[7:0];
                    2'd1:    store_word[15:8]  = wdata_q[7:0];
                    2'd2:    store_word[23:16] = wdata_q[7:0];
                    default: store_word[31:24] = wdata_q[7:0];
                endcase
            end
            F_H: begin
                if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
                else           store_word[15:0]  = wdata_q[15:0];
            end
            default: store_word = wdata_q;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready   = (state == S_IDLE);
        resp_valid  = (state == S_RESP);
        resp_error  = (state == S_RESP) && err_q;
        resp_rdata  = (state == S_RESP && !write_q && !err_q) ? load_val : 32'h0;
        mem_write   = (state == S_WRITE);
        mem_wdata   = (state == S_WRITE) ? store_word : 32'h0;
        mem_address = mem_addr_q;
        state_dbg   = state;
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_write(mem_write), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] mem [0:1023];
  assign mem_rdata = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'h0;
  always @(posedge clk)
    if (mem_write && mem_address < 32'd1024) mem[mem_address[9:0]] <= mem_wdata;

  // ---------------- counters / check helpers ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:1023];

  task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output int lat, output logic [31:0] nw, output logic [31:0] widx);
    int boff;
    int hoff;
    logic [31:0] w;
    logic [31:0] part;
    widx = addr >> 2;
    boff = int'(addr[1:0]) * 8;
    hoff = int'(addr[1]) * 16;
    rd = 32'h0;
    nw = 32'h0;
    if (wr) err = !(f3 inside {3'd0, 3'd1, 3'd2});
    else    err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (widx >= 32'd1024) err = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) err = 1'b1;
    if (f3 == 3'd2 && addr[1:0] != 2'b00) err = 1'b1;
`endif
    if (err) begin
      lat = 1;
      return;
    end
    w = ref_mem[widx[9:0]];
    if (!wr) begin
      lat = 2;
      case (f3)
        3'd0, 3'd4: begin
          part = (w >> boff) & 32'hFF;
          rd = (f3 == 3'd0 && part[7]) ? (part | 32'hFFFFFF00) : part;
        end
        3'd1, 3'd5: begin
          part = (w >> hoff) & 32'hFFFF;
          rd = (f3 == 3'd1 && part[15]) ? (part | 32'hFFFF0000) : part;
        end
        default: rd = w;
      endcase
    end else begin
      case (f3)
        3'd0: begin
          lat = 3;
          nw = (w & ~(32'hFF << boff)) | ((wd & 32'hFF) << boff);
        end
        3'd1: begin
          lat = 3;
          nw = (w & ~(32'hFFFF << hoff)) | ((wd & 32'hFFFF) << hoff);
        end
        default: begin
          lat = 2;
          nw = wd;
        end
      endcase
      ref_mem[widx[9:0]] = nw;
    end
  endtask

  // ---------------- scoreboard: expected queues ----------------
  logic [31:0] exp_rdata_q[$];
  logic [31:0] exp_word_q[$];
  logic [31:0] exp_widx_q[$];
  logic        exp_err_q[$];
  logic        exp_wr_q[$];
  int          exp_lat_q[$];

  int          n_done = 0;
  bit          in_flight = 1'b0;
  int          cyc;
  int          cur_lat;
  logic        cur_err, cur_wr;
  logic [31:0] cur_rd, cur_word, cur_widx;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 1'b0;
    end else if (in_flight) begin
      cyc++;
      check32("req_ready_busy", {31'h0, req_ready}, 32'h0);
      check32("resp_valid", {31'h0, resp_valid}, {31'h0, (cyc == cur_lat)});
      check32("mem_write", {31'h0, mem_write}, {31'h0, (cur_wr && cyc == cur_lat - 1)});
      if (cur_wr && cyc == cur_lat - 1) begin
        check32("mem_address", mem_address, cur_widx);
        check32("mem_wdata", mem_wdata, cur_word);
      end
      if (cyc >= cur_lat) begin
        check32("resp_rdata", resp_rdata, cur_rd);
        check32("resp_error", {31'h0, resp_error}, {31'h0, cur_err});
        last_rdata = resp_rdata;
        last_err = resp_error;
        in_flight = 1'b0;
        n_done++;
      end
    end else begin
      check32("req_ready_idle", {31'h0, req_ready}, 32'h1);
      check32("resp_valid_idle", {31'h0, resp_valid}, 32'h0);
      check32("mem_write_idle", {31'h0, mem_write}, 32'h0);
      if (req_valid && req_ready && exp_lat_q.size() > 0) begin
        cur_rd   = exp_rdata_q.pop_front();
        cur_word = exp_word_q.pop_front();
        cur_widx = exp_widx_q.pop_front();
        cur_err  = exp_err_q.pop_front();
        cur_wr   = exp_wr_q.pop_front();
        cur_lat  = exp_lat_q.pop_front();
        cyc = 0;
        in_flight = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [31:0] rd, input logic [31:0] nw, input logic [31:0] widx,
                          input logic err, input logic wr, input int lat);
    exp_rdata_q.push_back(rd);
    exp_word_q.push_back(nw);
    exp_widx_q.push_back(widx);
    exp_err_q.push_back(err);
    exp_wr_q.push_back(wr);
    exp_lat_q.push_back(lat);
  endtask

  task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    bit err;
    logic [31:0] rd, nw, widx;
    int lat;
    int target;
    model(wr, f3, addr, wd, err, rd, lat, nw, widx);
    push_exp(rd, nw, widx, err, wr && !err, lat);
    target = n_done + 1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = wr;
    req_funct3 = f3;
    req_addr = addr;
    req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr = $urandom_range(0, 32'h0FFF);
    for (int i = 0; i < 10 && n_done < target; i++) @(posedge clk);
    if (n_done < target) begin
      check32("resp_timeout", 32'h0, 32'h1);
    end else begin
      #1;
      if (!err) check32("mem_word", mem[widx[9:0]], ref_mem[widx[9:0]]);
    end
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check32("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check32("rst_resp_rdata", resp_rdata, 32'h0);
    check32("rst_resp_error", {31'h0, resp_error}, 32'h0);
    check32("rst_mem_write", {31'h0, mem_write}, 32'h0);
    check32("rst_mem_address", mem_address, 32'h0);
    check32("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;

    // word store / load
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    check32("lit_sw_word4", mem[4], 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    check32("lit_lw_rdata", last_rdata, 32'hDEADBEEF);
    check32("lit_lw_err", {31'h0, last_err}, 32'h0);

    // byte store into a known word
    issue(1'b1, 3'b010, 32'h10, 32'h11223344);
    issue(1'b1, 3'b000, 32'h12, 32'h000000AB);
    check32("lit_sb_word4", mem[4], 32'h11AB3344);

    // sign / zero extension
    issue(1'b0, 3'b000, 32'h12, 32'h0);
    check32("lit_lb", last_rdata, 32'hFFFFFFAB);
    issue(1'b0, 3'b100, 32'h12, 32'h0);
    check32("lit_lbu", last_rdata, 32'h000000AB);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    check32("lit_lh", last_rdata, 32'h000011AB);

    // misaligned word load
    issue(1'b0, 3'b010, 32'h13, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check32("lit_lw_mis_err", {31'h0, last_err}, 32'h1);
    check32("lit_lw_mis_rdata", last_rdata, 32'h0);
`else
    check32("lit_lw_mis_err", {31'h0, last_err}, 32'h0);
    check32("lit_lw_mis_rdata", last_rdata, 32'h11AB3344);
`endif

    // out of range store, illegal funct3 codes
    issue(1'b1, 3'b010, 32'h1000, 32'h12345678);
    check32("lit_range_err", {31'h0, last_err}, 32'h1);
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b0, 3'b111, 32'h10, 32'h0);
    issue(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF);
    check32("lit_bad_f3_err", {31'h0, last_err}, 32'h1);
    check32("lit_word4_kept", mem[4], 32'h11AB3344);

    // halfword store / loads, upper half
    issue(1'b1, 3'b010, 32'h14, 32'hA5A5A5A5);
    issue(1'b1, 3'b001, 32'h16, 32'h1234CAFE);
    check32("lit_sh_word5", mem[5], 32'hCAFEA5A5);
    issue(1'b0, 3'b101, 32'h16, 32'h0);
    check32("lit_lhu", last_rdata, 32'h0000CAFE);
    issue(1'b0, 3'b001, 32'h16, 32'h0);
    check32("lit_lh_neg", last_rdata, 32'hFFFFCAFE);
    issue(1'b1, 3'b001, 32'h17, 32'h00004321);
    issue(1'b0, 3'b101, 32'h15, 32'h0);

    // every byte lane of one word
    issue(1'b1, 3'b010, 32'h18, 32'h0);
    for (int i = 0; i < 4; i++) issue(1'b1, 3'b000, 32'h18 + i, 32'hFFFFFF10 + i);
    issue(1'b0, 3'b010, 32'h18, 32'h0);
    check32("lit_lanes", last_rdata, 32'h13121110);
    for (int i = 0; i < 4; i++) issue(1'b0, 3'b000, 32'h18 + i, 32'h0);

    // top word of memory
    issue(1'b1, 3'b010, 32'hFFC, 32'h0BADF00D);
    issue(1'b0, 3'b010, 32'hFFC, 32'h0);
    check32("lit_top_word", last_rdata, 32'h0BADF00D);

    // reset during the read phase of a byte store
    issue(1'b1, 3'b010, 32'h20, 32'h55667788);
    push_exp(32'h0, 32'h0, 32'h8, 1'b0, 1'b1, 3);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_funct3 = 3'b000;
    req_addr = 32'h20;
    req_wdata = 32'h000000EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check32("midrst_mem_write", {31'h0, mem_write}, 32'h0);
    rst = 1'b0;
    check32("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    check32("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check32("midrst_mem_address", mem_address, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check32("midrst_word8", mem[8], 32'h55667788);

    // traffic resumes normally after the reset
    issue(1'b0, 3'b100, 32'h21, 32'h0);
    check32("lit_after_rst", last_rdata, 32'h00000077);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
